stim_check_engine: RTL and testbench

Synthesizable stimulus-and-compare engine for on-chip equivalence checking of a design against its post-route netlist. It drives a pseudo-random 32-bit stimulus bus into two instances of the same top: the golden RTL and the routed netlist. It samples both output buses after a fixed settle interval and counts mismatches. It is the hardware counterpart of the post-route simulation bench: it produces stimulus and judges responses instead of a simulator doing so.

---
 rtl/stim_check_pkg.sv | 27 ++
 rtl/stim_check_engine_lfsr32.sv | 29 ++
 rtl/stim_check_engine.sv | 158 +++++++++++++++
 tb/tb_stim_check_engine.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stim_check_pkg.sv
// Shared types and constants for the stimulus-and-compare engine.
//   state_t      : engine FSM states
//   LFSR_MASK    : Galois feedback mask for taps 32,22,2,1
//   IDX_NONE     : fail_idx value when no mismatch has been seen
//   IDX_POSTRST  : fail_idx value for a mismatch found during the post-reset check
//   lfsr_next()  : one Galois LFSR step
package stim_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_RCHK,
        ST_APPLY,
        ST_WAIT,
        ST_CHECK,
        ST_FIN
    } state_t;

    localparam logic [31:0] LFSR_MASK   = 32'h8020_0003;
    localparam logic [15:0] IDX_NONE    = 16'hFFFF;
    localparam logic [15:0] IDX_POSTRST = 16'hFFFE;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? LFSR_MASK : '0);
    endfunction

endpackage

// File: rtl/stim_check_engine_lfsr32.sv
// 32-bit Galois LFSR stimulus source.
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset, loads SEED
//   load    : reload SEED (has priority over advance)
//   advance : step the LFSR once
//   value   : current LFSR state
module lfsr32
    import stim_check_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2345
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    output logic [31:0] value
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= SEED;
        end else if (load) begin
            value <= SEED;
        end else if (advance) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/stim_check_engine.sv
// Stimulus-and-compare engine: drives pseudo-random vectors into a golden and a
// netlist instance of the same design and counts output mismatches.
//   clk, rst          : clock; asynchronous active-low reset
//   start             : pulse to begin a run (accepted in idle or in the done cycle)
//   dut_rst           : active-high reset for both design instances
//   stim              : registered stimulus bus
//   golden_out        : golden instance outputs
//   netlist_out       : netlist instance outputs
//   busy, done, pass  : run status; done is a one-cycle end-of-run pulse
//   mismatch_cnt      : saturating mismatch count of the current/last run
//   fail_idx          : vector index of the first mismatch (16'hFFFE post-reset, 16'hFFFF none)
//   fail_golden/netlist : buses captured at the first mismatch
module stim_check_engine
    import stim_check_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned VECTORS = 1000,
    parameter int unsigned SETTLE  = 2,
    parameter logic [31:0] SEED    = 32'hACE1_2345
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             dut_rst,
    output logic [WIDTH-1:0] stim,
    input  logic [WIDTH-1:0] golden_out,
    input  logic [WIDTH-1:0] netlist_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      mismatch_cnt,
    output logic [15:0]      fail_idx,
    output logic [WIDTH-1:0] fail_golden,
    output logic [WIDTH-1:0] fail_netlist
);

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic [15:0] vec_idx;
    logic        launch;
    logic        compare;
    logic        mismatch;
    logic        last_vec;
    logic        pass_q;
    logic [31:0] lfsr_val;

    lfsr32 #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (launch),
        .advance (state == ST_APPLY),
        .value   (lfsr_val)
    );

    // Case inequality so that an X/Z on either bus counts as a mismatch in simulation.
    assign mismatch = (golden_out !== netlist_out);
    assign last_vec = (({1'b0, vec_idx} + 17'd1) == 17'(VECTORS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        launch   = 1'b0;
        compare  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_RESET;
                    launch   = 1'b1;
                end
            end
            ST_RESET: begin
                if (cnt == 4'd1) state_nx = ST_RCHK;
            end
            ST_RCHK: begin
                compare  = 1'b1;
                state_nx = ST_APPLY;
            end
            ST_APPLY: begin
                state_nx = (SETTLE == 1) ? ST_CHECK : ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt == 4'(SETTLE - 2)) state_nx = ST_CHECK;
            end
            ST_CHECK: begin
                compare  = 1'b1;
                state_nx = last_vec ? ST_FIN : ST_APPLY;
            end
            ST_FIN: begin
                // A start coinciding with done chains straight into a new run.
                if (start) begin
                    state_nx = ST_RESET;
                    launch   = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            vec_idx      <= '0;
            dut_rst      <= 1'b1;
            stim         <= '0;
            mismatch_cnt <= '0;
            fail_idx     <= IDX_NONE;
            fail_golden  <= '0;
            fail_netlist <= '0;
            pass_q       <= 1'b0;
        end else begin
            // One counter serves both the RESET hold and the WAIT settle interval;
            // it restarts from zero whenever the state changes.
            if ((state_nx == state) && (state == ST_RESET || state == ST_WAIT)) begin
                cnt <= cnt + 4'd1;
            end else begin
                cnt <= '0;
            end
            dut_rst <= (state_nx == ST_RESET) || (state_nx == ST_RCHK);

            if (launch) begin
                vec_idx      <= '0;
                stim         <= '0;
                mismatch_cnt <= '0;
                fail_idx     <= IDX_NONE;
                fail_golden  <= '0;
                fail_netlist <= '0;
                pass_q       <= 1'b0;
            end else begin
                if (state == ST_APPLY) stim <= lfsr_val[WIDTH-1:0];
                if (state == ST_CHECK && !last_vec) vec_idx <= vec_idx + 16'd1;
                if (compare && mismatch) begin
                    if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 16'd1;
                    // The count never returns to zero within a run, so zero marks the first hit.
                    if (mismatch_cnt == '0) begin
                        fail_idx     <= (state == ST_RCHK) ? IDX_POSTRST : vec_idx;
                        fail_golden  <= golden_out;
                        fail_netlist <= netlist_out;
                    end
                end
                if (state == ST_FIN) pass_q <= (mismatch_cnt == '0);
            end
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_FIN);
    assign pass = (state == ST_FIN) ? (mismatch_cnt == '0) : pass_q;

endmodule

// File: tb/tb_stim_check_engine.sv
module tb_stim_check_engine;

    localparam int V     = 1000;
    localparam int S     = 2;
    localparam int FIN_N = 3 + V * (S + 1);   // cycle index of done, counted from the launch edge
    localparam logic [31:0] SEED_V = 32'hACE1_2345;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        dut_rst, busy, done, pass;
    logic [31:0] stim, golden_out, netlist_out, fail_golden, fail_netlist;
    logic [15:0] mismatch_cnt, fail_idx;

    logic        start_s = 1'b0;
    logic        dut_rst_s, busy_s, done_s, pass_s;
    logic [31:0] stim_s, fail_golden_s, fail_netlist_s;
    logic [15:0] mismatch_cnt_s, fail_idx_s;

    stim_check_engine #(.WIDTH(32), .VECTORS(V), .SETTLE(S), .SEED(SEED_V)) u_dut (
        .clk(clk), .rst(rst), .start(start), .dut_rst(dut_rst), .stim(stim),
        .golden_out(golden_out), .netlist_out(netlist_out), .busy(busy), .done(done),
        .pass(pass), .mismatch_cnt(mismatch_cnt), .fail_idx(fail_idx),
        .fail_golden(fail_golden), .fail_netlist(fail_netlist)
    );

    stim_check_engine #(.WIDTH(32), .VECTORS(3), .SETTLE(1), .SEED(SEED_V)) u_small (
        .clk(clk), .rst(rst), .start(start_s), .dut_rst(dut_rst_s), .stim(stim_s),
        .golden_out(stim_s), .netlist_out(stim_s), .busy(busy_s), .done(done_s),
        .pass(pass_s), .mismatch_cnt(mismatch_cnt_s), .fail_idx(fail_idx_s),
        .fail_golden(fail_golden_s), .fail_netlist(fail_netlist_s)
    );

    int unsigned cyc = 0;
    int          c0  = 1 << 30;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] err_tab [V];
    logic [31:0] rchk_err = '0;
    logic [31:0] model   [V];
    int n_cmp = 0;
    int n_bad = 0;

    // Golden instance modelled as a wire; the netlist copy is the golden value with
    // a per-vector fault mask chosen by the bench's own view of the run timeline.
    assign golden_out = stim;
    always_comb begin : fault_model
        int n;
        logic [31:0] f;
        n = int'(cyc) - c0;
        f = '0;
        if (n == 2) f = rchk_err;
        else if (n >= 3 && n < FIN_N) f = err_tab[(n - 3) / (S + 1)];
        netlist_out = golden_out ^ f;
    end

    function automatic logic [31:0] galois_step(input logic [31:0] v);
        logic [31:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_faults(input logic [31:0] rchk, input int from, input logic [31:0] mask);
        rchk_err = rchk;
        for (int k = 0; k < V; k++) err_tab[k] = (from >= 0 && k >= from) ? mask : '0;
    endtask

    task automatic expect_from_tab(output int cnt, output logic [15:0] idx,
                                   output logic [31:0] g, output logic [31:0] nl);
        cnt = 0; idx = 16'hFFFF; g = '0; nl = '0;
        if (rchk_err != 0) begin
            cnt = 1; idx = 16'hFFFE; nl = rchk_err;
        end
        for (int k = 0; k < V; k++) begin
            if (err_tab[k] != 0) begin
                if (cnt == 0) begin
                    idx = 16'(k); g = model[k]; nl = model[k] ^ err_tab[k];
                end
                cnt++;
            end
        end
    endtask

    // Call right after a negedge: start is sampled at the following posedge.
    task automatic launch();
        start = 1'b1;
        c0 = int'(cyc) + 1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_wait(input bit spam, output int done_n, output int stim_bad, output int ctl_bad);
        int n;
        done_n = -1; stim_bad = 0; ctl_bad = 0;
        for (int i = 0; i < FIN_N + 20; i++) begin
            @(negedge clk);
            n = int'(cyc) - c0;
            start = spam && n >= 0 && n < FIN_N - 1 && (n % 5 == 1);
            if (n >= 0 && n <= 2 && (stim !== 32'h0 || dut_rst !== 1'b1)) ctl_bad++;
            if (n >= 3 && n < FIN_N && dut_rst !== 1'b0) ctl_bad++;
            if (n >= 0 && n < FIN_N && busy !== 1'b1) ctl_bad++;
            if (n >= 3 && n < FIN_N && ((n - 3) % (S + 1)) == S && stim !== model[(n - 3) / (S + 1)])
                stim_bad++;
            if (done === 1'b1) begin
                done_n = n;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string tag, input int done_n, input int stim_bad, input int ctl_bad,
                             input int exp_cnt, input logic [15:0] exp_idx, input logic [31:0] exp_g,
                             input logic [31:0] exp_n, input logic exp_pass);
        chk({tag, "_done_at"},  64'(done_n),    64'(FIN_N));
        chk({tag, "_stim_seq"}, 64'(stim_bad),  64'd0);
        chk({tag, "_ctrl"},     64'(ctl_bad),   64'd0);
        chk({tag, "_cnt"},      64'(mismatch_cnt), 64'(exp_cnt));
        chk({tag, "_idx"},      64'(fail_idx),  64'(exp_idx));
        chk({tag, "_fgold"},    64'(fail_golden),  64'(exp_g));
        chk({tag, "_fnet"},     64'(fail_netlist), 64'(exp_n));
        chk({tag, "_pass"},     64'(pass),      64'(exp_pass));
    endtask

    typedef struct {
        logic [31:0] rchk;
        int          from;
        logic [31:0] mask;
        int          exp_cnt;
        logic [15:0] exp_idx;
        logic        exp_pass;
    } row_t;

    row_t rows [5];

    initial begin
        int done_n, stim_bad, ctl_bad, cnt, dcount, got_done;
        logic [15:0] idx;
        logic [31:0] g, nl;
        logic [31:0] cap [3];
        string tag;

        rows[0] = '{32'h0, -1, 32'h0,         0,    16'hFFFF, 1'b1};
        rows[1] = '{32'h0, 10, 32'h8,         990,  16'd10,   1'b0};
        rows[2] = '{32'h1, -1, 32'h0,         1,    16'hFFFE, 1'b0};
        rows[3] = '{32'h0, 999, 32'h8000_0000, 1,   16'd999,  1'b0};
        rows[4] = '{32'h0, 0,  32'hFFFF_FFFF, 1000, 16'd0,    1'b0};

        model[0] = SEED_V;
        for (int k = 1; k < V; k++) model[k] = galois_step(model[k - 1]);
        set_faults('0, -1, '0);

        #1 rst = 1'b0;
        #2;
        chk("rst_dut_rst", 64'(dut_rst), 64'd1);
        chk("rst_stim",    64'(stim),    64'd0);
        chk("rst_busy",    64'(busy),    64'd0);
        chk("rst_done",    64'(done),    64'd0);
        chk("rst_pass",    64'(pass),    64'd0);
        chk("rst_cnt",     64'(mismatch_cnt), 64'd0);
        chk("rst_idx",     64'(fail_idx), 64'hFFFF);
        chk("rst_fgold",   64'(fail_golden),  64'd0);
        chk("rst_fnet",    64'(fail_netlist), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_dut_rst", 64'(dut_rst), 64'd0);

        // Table-driven fault scenarios.
        for (int r = 0; r < 5; r++) begin
            set_faults(rows[r].rchk, rows[r].from, rows[r].mask);
            expect_from_tab(cnt, idx, g, nl);
            @(negedge clk);
            launch();
            run_wait(1'b0, done_n, stim_bad, ctl_bad);
            tag = $sformatf("row%0d", r);
            check_run(tag, done_n, stim_bad, ctl_bad, rows[r].exp_cnt, rows[r].exp_idx, g, nl, rows[r].exp_pass);
            @(negedge clk);
            chk({tag, "_done_pulse"}, 64'(done), 64'd0);
            chk({tag, "_busy_after"}, 64'(busy), 64'd0);
            chk({tag, "_pass_hold"},  64'(pass), 64'(rows[r].exp_pass));
        end

        // Randomized fault patterns against the reference model.
        for (int r = 0; r < 3; r++) begin
            rchk_err = ($urandom_range(0, 2) == 0) ? ($urandom | 32'h1) : 32'h0;
            for (int k = 0; k < V; k++)
                err_tab[k] = ($urandom_range(0, 49) == 0) ? ($urandom | 32'h1) : 32'h0;
            expect_from_tab(cnt, idx, g, nl);
            @(negedge clk);
            launch();
            run_wait(1'b0, done_n, stim_bad, ctl_bad);
            check_run($sformatf("rand%0d", r), done_n, stim_bad, ctl_bad, cnt, idx, g, nl, cnt == 0);
        end

        // Asynchronous reset in the middle of a run.
        set_faults('0, 0, 32'h10);
        @(negedge clk);
        launch();
        for (int i = 0; i < 200 && (int'(cyc) - c0) < 100; i++) @(negedge clk);
        chk("abort_pre_cnt", 64'(mismatch_cnt), 64'd32);
        #2 rst = 1'b0;
        #1;
        chk("abort_dut_rst", 64'(dut_rst), 64'd1);
        chk("abort_stim",    64'(stim),    64'd0);
        chk("abort_busy",    64'(busy),    64'd0);
        chk("abort_done",    64'(done),    64'd0);
        chk("abort_cnt",     64'(mismatch_cnt), 64'd0);
        chk("abort_idx",     64'(fail_idx), 64'hFFFF);
        chk("abort_fgold",   64'(fail_golden), 64'd0);
        @(negedge clk) rst = 1'b1;
        dcount = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        chk("abort_no_done", 64'(dcount), 64'd0);
        set_faults('0, -1, '0);
        @(negedge clk);
        launch();
        run_wait(1'b0, done_n, stim_bad, ctl_bad);
        check_run("after_abort", done_n, stim_bad, ctl_bad, 0, 16'hFFFF, 32'h0, 32'h0, 1'b1);

        // start spammed while busy: one run, one done.
        @(negedge clk);
        launch();
        run_wait(1'b1, done_n, stim_bad, ctl_bad);
        check_run("spam", done_n, stim_bad, ctl_bad, 0, 16'hFFFF, 32'h0, 32'h0, 1'b1);
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        chk("spam_single_done", 64'(dcount), 64'd0);
        chk("spam_idle", 64'(busy), 64'd0);

        // start in the done cycle chains a new run with cleared results.
        set_faults('0, 5, 32'h1);
        expect_from_tab(cnt, idx, g, nl);
        @(negedge clk);
        launch();
        run_wait(1'b0, done_n, stim_bad, ctl_bad);
        check_run("chain1", done_n, stim_bad, ctl_bad, 995, 16'd5, g, nl, 1'b0);
        set_faults('0, -1, '0);
        launch();
        chk("chain_cnt_clr",  64'(mismatch_cnt), 64'd0);
        chk("chain_idx_clr",  64'(fail_idx), 64'hFFFF);
        chk("chain_busy",     64'(busy), 64'd1);
        chk("chain_pass_clr", 64'(pass), 64'd0);
        run_wait(1'b0, done_n, stim_bad, ctl_bad);
        check_run("chain2", done_n, stim_bad, ctl_bad, 0, 16'hFFFF, 32'h0, 32'h0, 1'b1);

        // Small instance: VECTORS=3, SETTLE=1.
        @(negedge clk) start_s = 1'b1;
        @(posedge clk);
        #1 start_s = 1'b0;
        got_done = -1;
        for (int k = 0; k < 3; k++) cap[k] = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 4 || i == 6 || i == 8) cap[(i - 4) / 2] = stim_s;
            if (done_s === 1'b1) begin
                got_done = i;
                break;
            end
        end
        chk("small_done_at", 64'(got_done), 64'd9);
        for (int k = 0; k < 3; k++) chk($sformatf("small_stim%0d", k), 64'(cap[k]), 64'(model[k]));
        chk("small_pass", 64'(pass_s), 64'd1);
        chk("small_cnt",  64'(mismatch_cnt_s), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
